// File: rtl/sys1_pkg.sv
// Shared constants and types for the SEGASYSTEM1 input conditioner.
// Bit positions within the captured mode byte and the merged joystick word.
package sys1_pkg;

    localparam int unsigned SM_DUAL   = 3;
    localparam int unsigned SM_SPIN   = 5;

    localparam int unsigned JOY_R     = 0;
    localparam int unsigned JOY_L     = 1;
    localparam int unsigned JOY_D     = 2;
    localparam int unsigned JOY_U     = 3;
    localparam int unsigned JOY_RR    = 4;
    localparam int unsigned JOY_RL    = 5;
    localparam int unsigned JOY_RD    = 6;
    localparam int unsigned JOY_RU    = 7;
    localparam int unsigned JOY_TRIG  = 8;
    localparam int unsigned JOY_ST1   = 9;
    localparam int unsigned JOY_ST2   = 10;
    localparam int unsigned JOY_COIN  = 11;
    localparam int unsigned JOY_PAUSE = 12;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        WAIT
    } coin_state_t;

endpackage

// File: rtl/sys1_coin_pulse.sv
// Turns a coin button press into a pulse lasting COIN_FRAMES vsync rising edges,
// one pulse per press regardless of how long the button is held.
module sys1_coin_pulse
    import sys1_pkg::*;
#(
    parameter int unsigned COIN_FRAMES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic coin,
    input  logic vs_rise,
    output logic coin_act
);

    localparam logic [3:0] LOAD = 4'(COIN_FRAMES);

    coin_state_t state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        coin_d;
    logic        coin_rise;

    assign coin_rise = coin & ~coin_d;

    // History loads the live level during reset so a button held through
    // reset is not mistaken for a fresh press afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            coin_d <= coin;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            coin_d <= coin;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        coin_act = 1'b0;
        unique case (state)
            IDLE: begin
                if (coin_rise) begin
                    state_nx = ACTIVE;
                    cnt_nx   = LOAD;
                end
            end
            ACTIVE: begin
                coin_act = 1'b1;
                if (vs_rise) begin
                    cnt_nx = cnt - 4'd1;
                    if (cnt <= 4'd1) state_nx = WAIT;
                end
            end
            WAIT: begin
                if (!coin) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/sys1_input_ctrl.sv
// Front-end conditioner between hps_io and the SEGASYSTEM1 core: config capture,
// pause/coin edge shaping, and active-low INP0/1/2 generation in three layouts.
module sys1_input_ctrl
    import sys1_pkg::*;
#(
    parameter int unsigned MODE_INDEX  = 1,
    parameter int unsigned DSW_INDEX   = 254,
    parameter int unsigned COIN_FRAMES = 3
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [15:0] joy,
    input  logic [7:0]  spin,
    input  logic [2:0]  mouse_btn,
    input  logic        vs,
    output logic [7:0]  sysmode,
    output logic [7:0]  dsw0,
    output logic [7:0]  dsw1,
    output logic [7:0]  inp0,
    output logic [7:0]  inp1,
    output logic [7:0]  inp2,
    output logic        pause_req
);

    // Config survives reset; it is only written by the ROM/DIP download stream.
    logic [7:0] sysmode_q = '0;
    logic [7:0] dsw_q [8] = '{default: '0};

    always_ff @(posedge clk_sys) begin
        if (ioctl_wr && ioctl_index == 8'(MODE_INDEX) && ioctl_addr == '0)
            sysmode_q <= ioctl_dout;
        if (ioctl_wr && ioctl_index == 8'(DSW_INDEX) && ioctl_addr[24:3] == '0)
            dsw_q[ioctl_addr[2:0]] <= ioctl_dout;
    end

    assign sysmode = sysmode_q;
    assign dsw0    = dsw_q[0];
    assign dsw1    = dsw_q[1];

    logic vs_d, vs_rise, pause_d, pause_q, coin_act;

    assign vs_rise = vs & ~vs_d;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            vs_d    <= 1'b0;
            pause_d <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            vs_d    <= vs;
            pause_d <= joy[JOY_PAUSE];
            if (joy[JOY_PAUSE] && !pause_d) pause_q <= ~pause_q;
        end
    end

    assign pause_req = pause_q;

    sys1_coin_pulse #(
        .COIN_FRAMES(COIN_FRAMES)
    ) u_coin (
        .clk      (clk_sys),
        .reset    (reset),
        .coin     (joy[JOY_COIN]),
        .vs_rise  (vs_rise),
        .coin_act (coin_act)
    );

    logic [7:0] stick_nx, sys_nx;
    logic       spin_trig;

    assign spin_trig = joy[JOY_RR] | (|mouse_btn);

    always_comb begin
        stick_nx = '1;
        sys_nx   = '1;
        if (sysmode_q[SM_SPIN]) begin
            stick_nx = ~spin;
            sys_nx   = ~{spin_trig, spin_trig, joy[JOY_ST2], joy[JOY_ST1], 3'b000, coin_act};
        end else if (sysmode_q[SM_DUAL]) begin
            stick_nx = ~{joy[JOY_L], joy[JOY_R], joy[JOY_U], joy[JOY_D],
                         joy[JOY_RL], joy[JOY_RR], joy[JOY_RU], joy[JOY_RD]};
            sys_nx   = ~{joy[JOY_TRIG], joy[JOY_TRIG], joy[JOY_ST2], joy[JOY_ST1], 3'b000, coin_act};
        end else begin
            stick_nx = ~{joy[JOY_L], joy[JOY_R], joy[JOY_U], joy[JOY_D],
                         1'b0, joy[JOY_RL], joy[JOY_RR], joy[JOY_RD]};
            sys_nx   = ~{2'b00, joy[JOY_ST2], joy[JOY_ST1], 3'b000, coin_act};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            inp0 <= '1;
            inp1 <= '1;
            inp2 <= '1;
        end else begin
            inp0 <= stick_nx;
            inp1 <= stick_nx;
            inp2 <= sys_nx;
        end
    end

    logic unused_joy;
    assign unused_joy = &{1'b0, joy[15:13]};

endmodule

// File: tb/tb_sys1_input_ctrl.sv
// Scoreboard bench for sys1_input_ctrl: stimulus queues expected values with a
// due cycle; a negedge monitor pops and compares them against the outputs.
module tb_sys1_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] joy;
    logic [7:0]  spin;
    logic [2:0]  mouse_btn;
    logic        vs;
    logic [7:0]  sysmode, dsw0, dsw1, inp0, inp1, inp2;
    logic        pause_req;

    sys1_input_ctrl #(
        .MODE_INDEX (1),
        .DSW_INDEX  (254),
        .COIN_FRAMES(3)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ioctl_wr   (ioctl_wr),
        .ioctl_index(ioctl_index),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .joy        (joy),
        .spin       (spin),
        .mouse_btn  (mouse_btn),
        .vs         (vs),
        .sysmode    (sysmode),
        .dsw0       (dsw0),
        .dsw1       (dsw1),
        .inp0       (inp0),
        .inp1       (inp1),
        .inp2       (inp2),
        .pause_req  (pause_req)
    );

    always #5 clk_sys = ~clk_sys;

    typedef enum int {S_INP0, S_INP1, S_INP2, S_SYSMODE, S_DSW0, S_DSW1, S_PAUSE} sel_t;

    typedef struct {
        int         due;
        sel_t       sel;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    function automatic logic [7:0] actual(sel_t s);
        case (s)
            S_INP0:    return inp0;
            S_INP1:    return inp1;
            S_INP2:    return inp2;
            S_SYSMODE: return sysmode;
            S_DSW0:    return dsw0;
            S_DSW1:    return dsw1;
            default:   return {7'd0, pause_req};
        endcase
    endfunction

    always @(negedge clk_sys) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                logic [7:0] a;
                a = actual(sb[i].sel);
                n_checks++;
                if (a !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: got %02h expected %02h (cycle %0d)", sb[i].name, a, sb[i].exp, cyc);
                end
                sb.delete(i);
            end
        end
    end

    task automatic expect_v(int lat, sel_t s, logic [7:0] v, string name);
        exp_t e;
        e.due  = cyc + lat;
        e.sel  = s;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic io_wr(logic [7:0] idx, logic [24:0] addr, logic [7:0] d);
        ioctl_index = idx;
        ioctl_addr  = addr;
        ioctl_dout  = d;
        ioctl_wr    = 1'b1;
        tick(1);
        ioctl_wr    = 1'b0;
    endtask

    task automatic vs_pulse(int n);
        repeat (n) begin
            vs = 1'b1;
            tick(1);
            vs = 1'b0;
            tick(3);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ioctl_wr = 1'b0; ioctl_index = '0; ioctl_addr = '0; ioctl_dout = '0;
        joy = '0; spin = '0; mouse_btn = '0; vs = 1'b0;
        tick(2);
        expect_v(0, S_INP0, 8'hFF, "rst_inp0");
        expect_v(0, S_INP1, 8'hFF, "rst_inp1");
        expect_v(0, S_INP2, 8'hFF, "rst_inp2");
        expect_v(0, S_PAUSE, 8'h00, "rst_pause");
        expect_v(0, S_SYSMODE, 8'h00, "rst_sysmode");
        tick(1);
        reset = 1'b0;

        // Config capture, one write concurrent with reset, then survival of reset
        io_wr(8'd1, 25'd0, 8'h28);
        io_wr(8'd254, 25'd0, 8'hA5);
        reset = 1'b1;
        io_wr(8'd254, 25'd1, 8'h3C);
        tick(2);
        reset = 1'b0;
        tick(1);
        expect_v(0, S_SYSMODE, 8'h28, "cfg_sysmode");
        expect_v(0, S_DSW0, 8'hA5, "cfg_dsw0");
        expect_v(0, S_DSW1, 8'h3C, "cfg_dsw1");
        io_wr(8'd254, 25'd8, 8'hFF);
        io_wr(8'd1, 25'd1, 8'h00);
        io_wr(8'd2, 25'd0, 8'h77);
        expect_v(0, S_DSW0, 8'hA5, "dsw_addr8_ignored");
        expect_v(0, S_SYSMODE, 8'h28, "sysmode_other_addr_ignored");

        // Spinner layout (sysmode 0x28 has both bits set; spinner wins)
        spin = 8'h5A; mouse_btn = 3'b001;
        tick(1);
        expect_v(1, S_INP0, 8'hA5, "spin_inp0");
        expect_v(1, S_INP1, 8'hA5, "spin_inp1");
        expect_v(1, S_INP2, 8'h3F, "spin_inp2");
        tick(2);

        // Dual-stick layout
        io_wr(8'd1, 25'd0, 8'h08);
        spin = '0; mouse_btn = '0; joy = 16'h0111;
        expect_v(1, S_INP0, 8'hBB, "dual_inp0");
        expect_v(1, S_INP1, 8'hBB, "dual_inp1");
        expect_v(1, S_INP2, 8'h3F, "dual_inp2");
        tick(2);

        // Standard layout
        io_wr(8'd1, 25'd0, 8'h00);
        joy = 16'h0011;
        expect_v(1, S_INP0, 8'hBD, "std_inp0");
        expect_v(1, S_INP1, 8'hBD, "std_inp1");
        expect_v(1, S_INP2, 8'hFF, "std_inp2");
        tick(2);
        joy = 16'h0600;
        expect_v(1, S_INP0, 8'hFF, "std_start_inp0");
        expect_v(1, S_INP2, 8'hCF, "std_start_inp2");
        tick(2);
        joy = '0;
        tick(2);

        // Coin held ten frames: exactly three frames of pulse
        joy[11] = 1'b1;
        expect_v(2, S_INP2, 8'hFE, "coin_start");
        tick(3);
        vs_pulse(2);
        expect_v(0, S_INP2, 8'hFE, "coin_after_2_frames");
        vs_pulse(1);
        expect_v(0, S_INP2, 8'hFF, "coin_after_3_frames");
        vs_pulse(7);
        expect_v(0, S_INP2, 8'hFF, "coin_held_no_repeat");
        joy[11] = 1'b0;
        tick(2);

        // Re-press during pulse does not extend or add a pulse
        joy[11] = 1'b1;
        tick(3);
        joy[11] = 1'b0;
        tick(2);
        joy[11] = 1'b1;
        tick(2);
        vs_pulse(3);
        expect_v(0, S_INP2, 8'hFF, "coin_repress_no_extend");
        vs_pulse(2);
        expect_v(0, S_INP2, 8'hFF, "coin_repress_no_extra");
        joy[11] = 1'b0;
        tick(2);
        joy[11] = 1'b1;
        expect_v(2, S_INP2, 8'hFE, "coin_new_press");
        tick(3);
        vs_pulse(3);
        joy[11] = 1'b0;
        tick(2);
        expect_v(0, S_INP2, 8'hFF, "coin_new_press_end");

        // Pause: one toggle per press, held button toggles once
        joy[12] = 1'b1;
        expect_v(1, S_PAUSE, 8'h01, "pause_press1");
        tick(2);
        vs_pulse(5);
        expect_v(0, S_PAUSE, 8'h01, "pause_held");
        joy[12] = 1'b0;
        tick(2);
        joy[12] = 1'b1;
        expect_v(1, S_PAUSE, 8'h00, "pause_press2");
        tick(2);
        vs_pulse(5);
        joy[12] = 1'b0;
        tick(2);
        expect_v(0, S_PAUSE, 8'h00, "pause_released");

        // Reset during an active pulse; held coin gives nothing until re-pressed
        joy[11] = 1'b1;
        tick(3);
        expect_v(0, S_INP2, 8'hFE, "rstcoin_active");
        reset = 1'b1;
        tick(1);
        expect_v(0, S_INP2, 8'hFF, "rstcoin_cleared");
        reset = 1'b0;
        tick(3);
        vs_pulse(2);
        expect_v(0, S_INP2, 8'hFF, "rstcoin_held_no_pulse");
        joy[11] = 1'b0;
        tick(2);
        joy[11] = 1'b1;
        expect_v(2, S_INP2, 8'hFE, "rstcoin_repress");
        tick(3);
        vs_pulse(3);
        joy[11] = 1'b0;
        tick(2);
        expect_v(0, S_INP2, 8'hFF, "rstcoin_repress_end");

        tick(3);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
